// File: rtl/i2c_burst_ctrl.sv
// Burst command sequencer driving the i2c_master byte handshake.
// Optional stall watchdog: define I2C_CTRL_TIMEOUT_EN (limit set by TIMEOUT_CYC).
module i2c_burst_ctrl #(
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_addr,
  input  logic             cmd_rw,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [6:0]       m_addr,
  output logic             m_rw,
  output logic             m_i2c_en,
  output logic [7:0]       m_tx_data,
  output logic             m_data_valid,
  output logic             m_read_last,
  input  logic             m_data_next,
  input  logic [7:0]       m_rx_data,
  input  logic             m_ready
);

  typedef enum logic [2:0] {IDLE, FETCH, START, XFER, DRAIN, FIN} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic             dv_q, dv_nxt, dv_drop;
  logic             err_q, err_nxt;
  logic [7:0]       tx_nxt;
  logic [6:0]       addr_nxt;
  logic             rw_nxt;
  logic             tmo;

  if (TIMEOUT_CYC < 1) begin : g_timeout_chk
    $error("TIMEOUT_CYC must be at least 1");
  end

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign err         = (state == FIN) && err_q;
  assign m_i2c_en    = (state == START);
  assign m_read_last = m_rw && (state == START || state == XFER) && (remaining == LEN_W'(1));
  // The master samples data_valid at the m_data_next pulse itself, so the
  // end-of-burst / underrun drop bypasses the register for that cycle.
  assign m_data_valid = dv_q && !dv_drop;

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    dv_nxt        = dv_q;
    dv_drop       = 1'b0;
    err_nxt       = err_q;
    tx_nxt        = m_tx_data;
    addr_nxt      = m_addr;
    rw_nxt        = m_rw;
    wr_ready      = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        addr_nxt      = cmd_addr;
        rw_nxt        = cmd_rw;
        remaining_nxt = cmd_len;
        if (cmd_len == '0) begin
          err_nxt   = 1'b1;
          state_nxt = FIN;
        end else if (cmd_rw) begin
          state_nxt = START;
        end else begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        wr_ready = wr_valid;
        if (wr_valid) begin
          tx_nxt    = wr_data;
          dv_nxt    = 1'b1;
          state_nxt = START;
        end
      end
      START: if (!m_ready) state_nxt = XFER;
      XFER: if (m_data_next && remaining != '0) begin
        remaining_nxt = remaining - 1'b1;
        if (m_rw) begin
          if (remaining == LEN_W'(1)) state_nxt = DRAIN;
        end else if (remaining == LEN_W'(1)) begin
          dv_nxt    = 1'b0;
          dv_drop   = 1'b1;
          state_nxt = DRAIN;
        end else if (wr_valid) begin
          wr_ready = 1'b1;
          tx_nxt   = wr_data;
        end else begin
          dv_nxt    = 1'b0;
          dv_drop   = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: if (m_ready) state_nxt = FIN;
      FIN: begin
        err_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (tmo) begin
      wr_ready  = 1'b0;
      tx_nxt    = m_tx_data;
      dv_nxt    = 1'b0;
      err_nxt   = 1'b1;
      state_nxt = FIN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
      m_tx_data <= '0;
      m_addr    <= '0;
      m_rw      <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      dv_q      <= dv_nxt;
      err_q     <= err_nxt;
      m_tx_data <= tx_nxt;
      m_addr    <= addr_nxt;
      m_rw      <= rw_nxt;
      rd_valid  <= (state == XFER) && m_rw && m_data_next && (remaining != '0);
      if ((state == XFER) && m_rw && m_data_next) rd_data <= m_rx_data;
    end
  end

`ifdef I2C_CTRL_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_cnt;
  logic               active;

  assign active = state inside {FETCH, START, XFER, DRAIN};
  assign tmo    = active && !m_data_next && (stall_cnt >= STALL_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (!active || m_data_next || state_nxt != state) stall_cnt <= '0;
    else stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_burst_ctrl.sv
// Self-checking bench for i2c_burst_ctrl with a behavioural i2c_master stand-in.
module tb_i2c_burst_ctrl;
  localparam int LEN_W = 4;
  localparam int TMO   = 50;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0, cmd_ready;
  logic [6:0]       cmd_addr = '0;
  logic             cmd_rw = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [7:0]       wr_data = '0;
  logic             wr_valid = 1'b0, wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid, busy, done, err;
  logic [6:0]       m_addr;
  logic             m_rw, m_i2c_en, m_data_valid, m_read_last;
  logic [7:0]       m_tx_data;
  logic             m_data_next = 1'b0;
  logic [7:0]       m_rx_data = '0;
  logic             m_ready = 1'b1;

  always #5 clk = ~clk;

  i2c_burst_ctrl #(.LEN_W(LEN_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .err(err),
    .m_addr(m_addr), .m_rw(m_rw), .m_i2c_en(m_i2c_en), .m_tx_data(m_tx_data),
    .m_data_valid(m_data_valid), .m_read_last(m_read_last),
    .m_data_next(m_data_next), .m_rx_data(m_rx_data), .m_ready(m_ready)
  );

  typedef struct packed {
    logic             rw;
    logic [6:0]       addr;
    logic [LEN_W-1:0] len;
    logic [4:0]       nbytes;
    logic [14:0][7:0] data;
    logic             exp_err;
    logic [4:0]       exp_hs;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       dv;
    logic       rl;
  } byte_exp_t;

  vec_t       tbl [10];
  byte_exp_t  exp_b[$];
  logic [7:0] exp_rd[$], slave_rd[$], wr_q[$];
  logic       exp_err[$];

  int   checks = 0, failures = 0;
  int   done_cnt = 0, rd_cnt = 0, en_cnt = 0, hs_cnt = 0;
  logic [6:0] cur_addr = '0;
  bit   hang = 1'b0;
  bit   hs_pending = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endfunction

  function automatic void miss(string name);
    checks++;
    failures++;
    $display("FAIL %s: DUT produced an output with nothing expected", name);
  endfunction

  function automatic vec_t mk(logic rw, logic [6:0] addr, int len, int nb,
                              logic [7:0] base, logic [7:0] step, logic e, int hs);
    vec_t v;
    logic [7:0] b;
    v = '0;
    v.rw = rw; v.addr = addr; v.len = LEN_W'(len); v.nbytes = 5'(nb);
    v.exp_err = e; v.exp_hs = 5'(hs);
    b = base;
    for (int i = 0; i < 15; i++) begin
      v.data[i] = b;
      b = b + step;
    end
    return v;
  endfunction

  // Master stand-in: 4-cycle byte slots, 3-cycle STOP.
  always @(posedge clk) begin : master_model
    static bit mact = 1'b0, mstop = 1'b0;
    static int mcnt = 0;
    byte_exp_t e;
    #1;
    m_data_next = 1'b0;
    if (rst) begin
      mact = 1'b0; mstop = 1'b0; mcnt = 0; m_ready = 1'b1;
    end else if (!mact) begin
      if (m_i2c_en && m_ready && !hang) begin
        mact = 1'b1; mstop = 1'b0; mcnt = 0; m_ready = 1'b0;
        chk("m_addr_at_start", 32'(m_addr), 32'(cur_addr));
      end
    end else if (mstop) begin
      mcnt++;
      if (mcnt >= 3) begin m_ready = 1'b1; mact = 1'b0; end
    end else begin
      mcnt++;
      if (mcnt >= 4) begin
        mcnt = 0;
        if (m_rw) m_rx_data = (slave_rd.size() != 0) ? slave_rd.pop_front() : 8'hEE;
        m_data_next = 1'b1;
        #1;
        if (exp_b.size() == 0) begin
          miss("byte_slot");
          mstop = 1'b1;
        end else begin
          e = exp_b.pop_front();
          if (!m_rw) begin
            chk("slave_wr_byte", 32'(m_tx_data), 32'(e.d));
            chk("dv_at_data_next", 32'(m_data_valid), 32'(e.dv));
            if (!m_data_valid) mstop = 1'b1;
          end else begin
            chk("read_last", 32'(m_read_last), 32'(e.rl));
            if (m_read_last) mstop = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) hs_pending = wr_valid && wr_ready;

  always @(posedge clk) begin : wr_stream
    #1;
    if (hs_pending && wr_q.size() != 0) begin
      void'(wr_q.pop_front());
      hs_cnt++;
    end
    wr_valid = (wr_q.size() != 0);
    wr_data  = wr_valid ? wr_q[0] : 8'h00;
  end

  always @(negedge clk) begin : monitor
    if (m_i2c_en) en_cnt++;
    if (rd_valid) begin
      rd_cnt++;
      if (exp_rd.size() == 0) miss("rd_data");
      else chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
    end
    if (done) begin
      done_cnt++;
      if (exp_err.size() == 0) miss("done");
      else chk("err_with_done", 32'(err), 32'(exp_err.pop_front()));
    end
  end

  task automatic flush_all();
    exp_b.delete(); exp_rd.delete(); slave_rd.delete(); wr_q.delete(); exp_err.delete();
  endtask

  task automatic run_cmd(input vec_t v);
    int d0, hs0, en0;
    @(posedge clk); #3;
    hs0 = hs_cnt; en0 = en_cnt;
    cur_addr = v.addr;
    exp_err.push_back(v.exp_err);
    if (v.len != 0) begin
      if (v.rw) begin
        for (int i = 0; i < int'(v.len); i++) begin
          slave_rd.push_back(v.data[i]);
          exp_rd.push_back(v.data[i]);
          exp_b.push_back('{d: v.data[i], dv: 1'b0, rl: (i == int'(v.len) - 1)});
        end
      end else begin
        for (int i = 0; i < int'(v.nbytes); i++) wr_q.push_back(v.data[i]);
        for (int i = 0; i < int'(v.len) && i < int'(v.nbytes); i++)
          exp_b.push_back('{d: v.data[i],
                            dv: (i + 1 < int'(v.len)) && (i + 1 < int'(v.nbytes)),
                            rl: 1'b0});
      end
    end
    @(posedge clk); #3;
    d0 = done_cnt;
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_rw = v.rw; cmd_len = v.len;
    @(posedge clk); #3;
    chk("en_one_cycle_after_accept", 32'(m_i2c_en), 32'(v.rw && v.len != 0));
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("len0_done_next_cycle", 32'(done), 32'(v.len == 0));
    if (v.len != 0) begin
      for (int i = 0; i < 2; i++) begin
        chk("cmd_ready_while_busy", 32'(cmd_ready), 32'd0);
        @(posedge clk); #3;
      end
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) begin
      checks++; failures++;
      $display("FAIL done_timeout: no done within 400 cycles for addr 0x%0h", v.addr);
    end
    #3;
    chk("wr_handshakes", 32'(hs_cnt - hs0), 32'(v.exp_hs));
    chk("bus_started", 32'(en_cnt != en0), 32'(v.len != 0));
    chk("all_bytes_seen", 32'(exp_b.size() + exp_rd.size()), 32'd0);
    flush_all();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int r0, n;
    tbl[0] = mk(1'b0, 7'h50, 3, 3, 8'h42, 8'h01, 1'b0, 3);
    tbl[1] = mk(1'b1, 7'h50, 2, 0, 8'h11, 8'h11, 1'b0, 0);
    tbl[2] = mk(1'b0, 7'h50, 3, 1, 8'h42, 8'h01, 1'b1, 1);
    tbl[3] = mk(1'b0, 7'h50, 0, 0, 8'h00, 8'h00, 1'b1, 0);
    tbl[4] = mk(1'b1, 7'h3A, 1, 0, 8'hA5, 8'h00, 1'b0, 0);
    tbl[5] = mk(1'b0, 7'h7F, 15, 15, 8'h80, 8'h03, 1'b0, 15);
    tbl[6] = mk(1'b1, 7'h01, 0, 0, 8'h00, 8'h00, 1'b1, 0);
    tbl[7] = mk(1'b0, 7'h2C, 2, 2, 8'hFF, 8'hF1, 1'b0, 2);
    tbl[8] = mk(1'b1, 7'h55, 4, 0, 8'h5A, 8'h25, 1'b0, 0);
    tbl[9] = mk(1'b0, 7'h10, 4, 2, 8'hC3, 8'h11, 1'b1, 2);

    repeat (3) @(posedge clk);
    #3;
    chk("reset_m_outputs", 32'({m_addr, m_rw, m_i2c_en, m_tx_data, m_data_valid, m_read_last}), 32'd0);
    chk("reset_status", 32'({busy, done, err, rd_valid, wr_ready}), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk) rst = 1'b0;

    for (int k = 0; k < 10; k++) run_cmd(tbl[k]);

    // Asynchronous reset in the middle of a 3-byte read.
    @(posedge clk); #3;
    cur_addr = 7'h50;
    for (int i = 0; i < 3; i++) begin
      slave_rd.push_back(8'(i + 1));
      exp_rd.push_back(8'(i + 1));
      exp_b.push_back('{d: 8'(i + 1), dv: 1'b0, rl: (i == 2)});
    end
    r0 = rd_cnt;
    cmd_valid = 1'b1; cmd_addr = 7'h50; cmd_rw = 1'b1; cmd_len = LEN_W'(3);
    @(posedge clk); #3;
    cmd_valid = 1'b0;
    for (int i = 0; i < 100 && rd_cnt == r0; i++) @(negedge clk);
    #2;
    chk("bytes_before_reset", 32'(rd_cnt - r0), 32'd1);
    rst = 1'b1;
    #1;
    chk("midburst_reset_m_outputs", 32'({m_addr, m_rw, m_i2c_en, m_tx_data, m_data_valid, m_read_last}), 32'd0);
    chk("midburst_reset_status", 32'({busy, done, err, rd_valid, wr_ready}), 32'd0);
    chk("midburst_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    flush_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_cmd(tbl[0]);

`ifdef I2C_CTRL_TIMEOUT_EN
    // Master never leaves idle: the watchdog must end the burst.
    hang = 1'b1;
    @(posedge clk); #3;
    exp_err.push_back(1'b1);
    cmd_valid = 1'b1; cmd_addr = 7'h50; cmd_rw = 1'b1; cmd_len = LEN_W'(2);
    @(posedge clk); #3;
    cmd_valid = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #3;
      n++;
    end
    checks++;
    if (n < TMO - 1 || n > TMO + 1) begin
      failures++;
      $display("FAIL timeout_cycles: got %0d cycles after START, required %0d+-1", n, TMO);
    end
    chk("timeout_en_dropped", 32'(m_i2c_en), 32'd0);
    chk("timeout_err", 32'(err), 32'd1);
    @(posedge clk); #3;
    hang = 1'b0;
    flush_all();
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_burst_ctrl.md
Name: i2c_burst_ctrl

Overview:
- Command-level sequencer in front of i2c_master: accepts one burst command (7-bit device address, direction, byte count) and drives the master's byte handshake until the burst completes.
- Write bytes arrive on a valid/ready stream; read bytes leave as single-cycle valid pulses.
- Sits between the register/host logic and i2c_master, so software never drives i2c_en, data_valid or read_last directly.

Parameters:
- LEN_W, 4: width of cmd_len; max burst = 2**LEN_W-1 bytes.
- TIMEOUT_CYC, 100000: stall limit in clk cycles (used only with I2C_CTRL_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&cmd_ready.
- cmd_addr  in  7  target device address.
- cmd_rw  in  1  0=write, 1=read.
- cmd_len  in  LEN_W  byte count.
- wr_data  in  8  write byte stream.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  byte consumed this cycle.
- rd_data  out  8  received byte.
- rd_valid  out  1  one-cycle pulse per received byte.
- busy  out  1  high in any state but IDLE.
- done  out  1  one-cycle pulse at end of every accepted command.
- err  out  1  valid with done: 1 = burst aborted or rejected.
- m_addr  out  7  to master addr.
- m_rw  out  1  to master rw.
- m_i2c_en  out  1  to master i2c_en.
- m_tx_data  out  8  to master tx_data.
- m_data_valid  out  1  to master data_valid.
- m_read_last  out  1  to master read_last.
- m_data_next  in  1  master pulse: tx byte taken (write) / rx_data valid (read).
- m_rx_data  in  8  master rx_data.
- m_ready  in  1  master idle.

Behaviour:
- Reset (async, immediate, also mid-burst): state IDLE; all outputs 0 except cmd_ready=1; remaining counter 0. Bus is released because m_i2c_en/m_data_valid drop.
- Master contract:
  - Master starts when m_i2c_en=1 while m_ready=1.
  - Write: master pulses m_data_next after each byte is ACKed; m_data_valid=0 at that pulse -> STOP.
  - Read: m_data_next marks m_rx_data valid; m_read_last=1 while a byte is received -> NACK+STOP after it.
- FSM states: IDLE, FETCH, START, XFER, DRAIN, FIN.
- IDLE:
  - On accept, latch addr/rw/len into m_addr/m_rw/remaining.
  - len==0 -> FIN with err=1, no bus activity.
  - write -> FETCH; read -> START.
- FETCH: wr_ready=wr_valid; on handshake load m_tx_data, m_data_valid=1 -> START.
- START: m_i2c_en=1 until m_ready samples 0 -> XFER, m_i2c_en=0.
- XFER write, on m_data_next:
  - remaining-=1.
  - New remaining==0: m_data_valid=0.
  - Else if wr_valid: wr_ready=1 combinationally in the same cycle, load next byte.
  - Else underrun: m_data_valid=0, set sticky err.
  - When remaining==0 or underrun -> DRAIN.
- XFER read:
  - m_read_last = (remaining==1).
  - On m_data_next: rd_data<=m_rx_data, rd_valid=1 next cycle, remaining-=1; new remaining==0 -> DRAIN.
- DRAIN: wait m_ready==1 (STOP complete) -> FIN.
- FIN: done=1 for one cycle, err=sticky error; clear sticky -> IDLE. cmd_ready returns 1 the cycle after done.
- Latency: cmd accept -> m_i2c_en high = 1 cycle for read; write needs the FETCH handshake first.
- cmd_valid during busy is ignored (cmd_ready=0); wr_ready is never 1 outside FETCH/XFER-write.
- remaining never wraps; a decrement is only applied when remaining>0.

Optional Feature:
- Macro I2C_CTRL_TIMEOUT_EN.
- Defined: stall counter clears on any state change or m_data_next, increments otherwise in FETCH/START/XFER/DRAIN. On reaching TIMEOUT_CYC: drop m_i2c_en and m_data_valid, err=1, -> FIN.
- Undefined: no counter logic; a burst may wait indefinitely; err only from len==0 or underrun.

Test Plan:
- Write addr 0x50, len=3, stream 0x42,0x43,0x44 pre-valid -> m_tx_data sequence 0x42,0x43,0x44; exactly 3 wr_ready pulses; done=1, err=0; slave sees 0x42..0x44.
- Read addr 0x50, len=2, slave returns 0x11,0x22 -> rd_valid pulses with 0x11 then 0x22; m_read_last high only for the 2nd byte; done, err=0.
- Write len=3, wr_valid dropped after the 1st byte -> m_data_valid=0 at the 1st m_data_next, STOP issued, done with err=1.
- cmd_len=0 -> done with err=1 within 2 cycles, m_i2c_en never asserted.
- Assert rst mid-read after 1 byte -> all m_* outputs 0 immediately, cmd_ready=1; a new write then completes normally.
- With I2C_CTRL_TIMEOUT_EN and TIMEOUT_CYC=50, m_ready held 1 (master hung) -> done with err=1 at cycle 50±1 after START, m_i2c_en=0.
